mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning maximum WAIT cycles before abort.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ex_mem_enable  input  1  EX/MEM slot holds a valid instruction.
REQ-006 ex_mem_memread  input  1  load.
REQ-007 ex_mem_memwrite  input  1  store.
REQ-008 ex_mem_regwrite  input  1  instruction writes rd.
REQ-009 ex_mem_memtoreg  input  1  writeback selects load data.
REQ-010 ex_mem_register_rd  input  5  destination register.
REQ-011 result_ex_mem  input  32  ALU result / memory address.
REQ-012 ex_mem_output_data_2  input  32  store data.
REQ-013 dmem_req  output  1  data-memory request.
REQ-014 dmem_we  output  1  1 = write, 0 = read.
REQ-015 dmem_addr  output  32  word address.
REQ-016 dmem_wdata  output  32  store data.
REQ-017 dmem_ack  input  1  memory completion, one-cycle pulse.
REQ-018 dmem_rdata  input  32  load data, valid with dmem_ack.
REQ-019 mem_stall  output  1  combinational; upstream holds EX/MEM while high.
REQ-020 mem_fault  output  1  one-cycle pulse on misalignment or timeout.
REQ-021 mem_wb_enable, mem_wb_regwrite, mem_wb_memtoreg  output  1 each  registered MEM/WB controls.
REQ-022 mem_wb_register_rd  output  5  registered rd.
REQ-023 mem_wb_result, mem_wb_read_data  output  32 each  registered ALU result and load data.

Function
REQ-024 The block SHALL treat an op as memory when ex_mem_enable && (memread || memwrite); memwrite wins if both are set.
REQ-025 FSM SHALL have states IDLE and WAIT, with a counter of width clog2(TIMEOUT_CYCLES).
REQ-026 In IDLE, a non-memory op or enable=0 SHALL pass to MEM/WB in 1 cycle with no stall; enable=0 loads a bubble (enable, regwrite, memtoreg = 0).
REQ-027 In IDLE, an aligned memory op (addr[1:0]=0) SHALL assert mem_stall, load request registers (req=1, we, addr, wdata), clear the counter, load a MEM/WB bubble, and enter WAIT.
REQ-028 In IDLE, a misaligned memory op SHALL issue no request and no stall, pulse mem_fault next cycle, and load a MEM/WB bubble.
REQ-029 In WAIT, dmem_req, dmem_we, dmem_addr, and dmem_wdata SHALL stay stable until ack or abort; mem_stall = !dmem_ack.
REQ-030 On dmem_ack in WAIT, the block SHALL load MEM/WB from the held EX/MEM inputs (enable=1; read_data = dmem_rdata for a load, 0 for a store; regwrite forced 0 for a store), drop dmem_req next edge, and return to IDLE.
REQ-031 In WAIT without ack, the counter SHALL increment each cycle; at TIMEOUT_CYCLES-1 the block SHALL abort: mem_fault pulse, MEM/WB bubble, req dropped, return to IDLE, mem_stall low that cycle.
REQ-032 Ack and timeout in the same cycle SHALL resolve as ack (completion).
REQ-033 dmem_ack in IDLE SHALL be ignored.
REQ-034 Total load/store latency SHALL be 1 issue cycle + N memory cycles + 1 register cycle; there SHALL be no double issue because stall drops in the ack cycle.

Reset
REQ-035 When rst=1, the block SHALL force IDLE, counter 0, and set dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_fault, and all mem_wb_* to 0; rst in WAIT drops req at that edge, and a later ack SHALL be ignored.

Verification
REQ-036 ALU op (rd=5, result=0x10, regwrite=1) -> next cycle mem_wb_enable=1, rd=5, result=0x10, no stall.
REQ-037 Load addr 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> mem_stall high 4 cycles, then mem_wb_read_data=0xDEADBEEF, memtoreg=1.
REQ-038 Store addr 0x204 data 0x55 -> dmem_we=1, addr/wdata stable until ack, mem_wb_regwrite=0.
REQ-039 Load addr 0x102 -> no dmem_req, mem_fault pulse 1 cycle, MEM/WB bubble.
REQ-040 Load with no ack -> abort after 16 WAIT cycles, mem_fault=1 once; ack on cycle 16 -> completes normally, no fault.
REQ-041 rst asserted mid-WAIT, then ack -> dmem_req=0 after edge, outputs 0, ack ignored.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage: issues data-memory requests, waits for ack or timeout,
// and registers the MEM/WB bundle for writeback.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_enable,
  input  logic        ex_mem_memread,
  input  logic        ex_mem_memwrite,
  input  logic        ex_mem_regwrite,
  input  logic        ex_mem_memtoreg,
  input  logic [4:0]  ex_mem_register_rd,
  input  logic [31:0] result_ex_mem,
  input  logic [31:0] ex_mem_output_data_2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        mem_wb_enable,
  output logic        mem_wb_regwrite,
  output logic        mem_wb_memtoreg,
  output logic [4:0]  mem_wb_register_rd,
  output logic [31:0] mem_wb_result,
  output logic [31:0] mem_wb_read_data
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic        wb_en_q, wb_en_d;
  logic        wb_rw_q, wb_rw_d;
  logic        wb_m2r_q, wb_m2r_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_res_q, wb_res_d;
  logic [31:0] wb_rdat_q, wb_rdat_d;

  logic is_mem;
  logic is_store;
  logic aligned;
  logic timeout;

  assign is_mem   = ex_mem_enable
                  & (ex_mem_memread | ex_mem_memwrite);
  assign is_store = ex_mem_memwrite;
  assign aligned  = (result_ex_mem[1:0] == 2'b00);
  assign timeout  = (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    fault_d   = 1'b0;
    wb_en_d   = 1'b0;
    wb_rw_d   = 1'b0;
    wb_m2r_d  = 1'b0;
    wb_rd_d   = 5'd0;
    wb_res_d  = 32'd0;
    wb_rdat_d = 32'd0;
    mem_stall = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          is_mem && aligned: begin
            mem_stall = 1'b1;
            req_d     = 1'b1;
            we_d      = is_store;
            addr_d    = result_ex_mem;
            wdata_d   = ex_mem_output_data_2;
            cnt_d     = '0;
            state_d   = S_WAIT;
          end
          is_mem && !aligned: fault_d = 1'b1;
          !is_mem && ex_mem_enable: begin
            wb_en_d  = 1'b1;
            wb_rw_d  = ex_mem_regwrite;
            wb_m2r_d = ex_mem_memtoreg;
            wb_rd_d  = ex_mem_register_rd;
            wb_res_d = result_ex_mem;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        // ack beats a same-cycle timeout
        if (dmem_ack) begin
          wb_en_d   = 1'b1;
          wb_rw_d   = ex_mem_regwrite & ~is_store;
          wb_m2r_d  = ex_mem_memtoreg;
          wb_rd_d   = ex_mem_register_rd;
          wb_res_d  = result_ex_mem;
          wb_rdat_d = is_store ? 32'd0 : dmem_rdata;
          req_d     = 1'b0;
          we_d      = 1'b0;
          addr_d    = 32'd0;
          wdata_d   = 32'd0;
          state_d   = S_IDLE;
        end else if (timeout) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'd0;
          wdata_d = 32'd0;
          state_d = S_IDLE;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      fault_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_rw_q   <= 1'b0;
      wb_m2r_q  <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_res_q  <= 32'd0;
      wb_rdat_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      fault_q   <= fault_d;
      wb_en_q   <= wb_en_d;
      wb_rw_q   <= wb_rw_d;
      wb_m2r_q  <= wb_m2r_d;
      wb_rd_q   <= wb_rd_d;
      wb_res_q  <= wb_res_d;
      wb_rdat_q <= wb_rdat_d;
    end
  end

  assign dmem_req           = req_q;
  assign dmem_we            = we_q;
  assign dmem_addr          = addr_q;
  assign dmem_wdata         = wdata_q;
  assign mem_fault          = fault_q;
  assign mem_wb_enable      = wb_en_q;
  assign mem_wb_regwrite    = wb_rw_q;
  assign mem_wb_memtoreg    = wb_m2r_q;
  assign mem_wb_register_rd = wb_rd_q;
  assign mem_wb_result      = wb_res_q;
  assign mem_wb_read_data   = wb_rdat_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: writebacks are queued at issue
// and compared by a monitor when mem_wb_enable appears.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_mem_enable = 1'b0;
  logic        ex_mem_memread = 1'b0;
  logic        ex_mem_memwrite = 1'b0;
  logic        ex_mem_regwrite = 1'b0;
  logic        ex_mem_memtoreg = 1'b0;
  logic [4:0]  ex_mem_register_rd = 5'd0;
  logic [31:0] result_ex_mem = 32'd0;
  logic [31:0] ex_mem_output_data_2 = 32'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        mem_stall;
  logic        mem_fault;
  logic        mem_wb_enable;
  logic        mem_wb_regwrite;
  logic        mem_wb_memtoreg;
  logic [4:0]  mem_wb_register_rd;
  logic [31:0] mem_wb_result;
  logic [31:0] mem_wb_read_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] rdat;
    logic        rw;
    logic        m2r;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  wb_t mon_o;
  int  checks = 0;
  int  errors = 0;

  mem_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_mem_enable        (ex_mem_enable),
    .ex_mem_memread       (ex_mem_memread),
    .ex_mem_memwrite      (ex_mem_memwrite),
    .ex_mem_regwrite      (ex_mem_regwrite),
    .ex_mem_memtoreg      (ex_mem_memtoreg),
    .ex_mem_register_rd   (ex_mem_register_rd),
    .result_ex_mem        (result_ex_mem),
    .ex_mem_output_data_2 (ex_mem_output_data_2),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_ack             (dmem_ack),
    .dmem_rdata           (dmem_rdata),
    .mem_stall            (mem_stall),
    .mem_fault            (mem_fault),
    .mem_wb_enable        (mem_wb_enable),
    .mem_wb_regwrite      (mem_wb_regwrite),
    .mem_wb_memtoreg      (mem_wb_memtoreg),
    .mem_wb_register_rd   (mem_wb_register_rd),
    .mem_wb_result        (mem_wb_result),
    .mem_wb_read_data     (mem_wb_read_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && mem_wb_enable) begin
      mon_o = '{mem_wb_register_rd, mem_wb_result,
                mem_wb_read_data, mem_wb_regwrite,
                mem_wb_memtoreg};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got=%h", mon_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_o !== mon_e) begin
          errors++;
          $display("FAIL wb_record got=%h exp=%h", mon_o, mon_e);
        end
      end
    end
  end

  task automatic drive(input logic en, input logic rd_, input logic wr_,
                       input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] dat);
    ex_mem_enable        = en;
    ex_mem_memread       = rd_;
    ex_mem_memwrite      = wr_;
    ex_mem_regwrite      = rw;
    ex_mem_memtoreg      = m2r;
    ex_mem_register_rd   = rd;
    result_ex_mem        = res;
    ex_mem_output_data_2 = dat;
  endtask

  task automatic idle_op();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_fault,
         mem_wb_enable, mem_wb_regwrite, mem_wb_memtoreg,
         mem_wb_register_rd, mem_wb_result, mem_wb_read_data,
         mem_stall} !== '0) begin
      errors++;
      $display("FAIL reset_state req=%b addr=%h wb_en=%b stall=%b exp=0",
               dmem_req, dmem_addr, mem_wb_enable, mem_stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h10, 32'h0);
    exp_q.push_back('{5'd5, 32'h10, 32'h0, 1'b1, 1'b0});
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall got=%b exp=0", mem_stall);
    end
    @(negedge clk);
    idle_op();
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL alu_req got=%b exp=0", dmem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_wb_enable !== 1'b0) begin
      errors++;
      $display("FAIL bubble_en got=%b exp=0", mem_wb_enable);
    end
  endtask

  task automatic test_load();
    int stalls = 0;
    int bad = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0);
    exp_q.push_back('{5'd7, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1});
    #1;
    if (mem_stall) stalls++;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 ||
          dmem_addr !== 32'h100) bad++;
      if (w == 3) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end
      #1;
      if (mem_stall) stalls++;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    idle_op();
    checks++;
    if (stalls != 4) begin
      errors++;
      $display("FAIL load_stall_cycles got=%0d exp=4", stalls);
    end
    checks++;
    if (bad != 0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL load_req bad=%0d req_after=%b exp=0/0",
               bad, dmem_req);
    end
  endtask

  task automatic test_store();
    int bad = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h204, 32'h55);
    exp_q.push_back('{5'd3, 32'h204, 32'h0, 1'b0, 1'b0});
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 ||
          dmem_addr !== 32'h204 || dmem_wdata !== 32'h55) bad++;
      if (w == 2) dmem_ack = 1'b1;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    idle_op();
    checks++;
    if (bad != 0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL store_bus bad=%0d req_after=%b exp=0/0",
               bad, dmem_req);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h102, 32'h0);
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL misalign_stall got=%b exp=0", mem_stall);
    end
    @(negedge clk);
    idle_op();
    checks++;
    if (dmem_req !== 1'b0 || mem_fault !== 1'b1 ||
        mem_wb_enable !== 1'b0) begin
      errors++;
      $display("FAIL misalign_fault req=%b fault=%b wb_en=%b exp=0/1/0",
               dmem_req, mem_fault, mem_wb_enable);
    end
    @(negedge clk);
    checks++;
    if (mem_fault !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse got=%b exp=0", mem_fault);
    end
  endtask

  task automatic test_timeout();
    int waits = 0;
    int faults = 0;
    int lows = 0;
    int wb_bad = 0;
    bit done = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h300, 32'h0);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_fault) begin
        faults++;
        if (mem_wb_enable) wb_bad++;
      end
      if (dmem_req) begin
        waits++;
        #1;
        if (!mem_stall) lows++;
      end else begin
        done = 1;
        idle_op();
      end
    end
    @(negedge clk);
    if (mem_fault) faults++;
    checks++;
    if (!done || waits != 16) begin
      errors++;
      $display("FAIL timeout_wait done=%0d got=%0d exp=16", done, waits);
    end
    checks++;
    if (faults != 1 || wb_bad != 0 || lows != 1) begin
      errors++;
      $display("FAIL timeout_fault faults=%0d wb=%0d low=%0d exp=1/0/1",
               faults, wb_bad, lows);
    end
  endtask

  task automatic test_ack_at_timeout();
    int waits = 0;
    int faults = 0;
    bit done = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h400, 32'h0);
    exp_q.push_back('{5'd11, 32'h400, 32'hCAFE0123, 1'b1, 1'b1});
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_fault) faults++;
      if (dmem_req) begin
        waits++;
        if (waits == 16) begin
          dmem_ack   = 1'b1;
          dmem_rdata = 32'hCAFE0123;
        end
      end else begin
        done = 1;
        dmem_ack = 1'b0;
        idle_op();
      end
    end
    @(negedge clk);
    if (mem_fault) faults++;
    checks++;
    if (!done || waits != 16 || faults != 0) begin
      errors++;
      $display("FAIL ack_on_timeout done=%0d waits=%0d faults=%0d exp=1/16/0",
               done, waits, faults);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h500, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_req got=%b exp=1", dmem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || dmem_addr !== 32'h0 ||
        mem_wb_enable !== 1'b0 || mem_fault !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wait req=%b addr=%h wb=%b fault=%b exp=0",
               dmem_req, dmem_addr, mem_wb_enable, mem_fault);
    end
    rst = 1'b0;
    idle_op();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || mem_wb_enable !== 1'b0 ||
        mem_fault !== 1'b0) begin
      errors++;
      $display("FAIL ack_ignored req=%b wb=%b fault=%b exp=0/0/0",
               dmem_req, mem_wb_enable, mem_fault);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 32'hA0, 32'h0);
    exp_q.push_back('{5'd1, 32'hA0, 32'h0, 1'b1, 1'b0});
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h600, 32'h0);
    exp_q.push_back('{5'd2, 32'h600, 32'h0BADF00D, 1'b1, 1'b1});
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_issue_stall got=%b exp=1", mem_stall);
    end
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'hB0, 32'h0);
    exp_q.push_back('{5'd6, 32'hB0, 32'h0, 1'b1, 1'b0});
    #1;
    checks++;
    if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_reissue stall=%b req=%b exp=0/0",
               mem_stall, dmem_req);
    end
    @(negedge clk);
    idle_op();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
